// File: rtl/bram1_load_client.sv
// Request/response initiator for a single-ported BRAM with 1- or 2-cycle read latency.
// Outstanding reads are capped by free response-FIFO space so returning read data always has a slot.
module bram1_load_client #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int LAT = (PIPELINED != 0) ? 2 : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         occ;
  logic [LAT-1:0]        rd_pipe;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         credits;
  logic                  accept;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits come only from registered state, so RSP_READY never reaches REQ_READY combinationally.
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      in_flight = in_flight + CW'(rd_pipe[i]);
    end
    credits = occ + in_flight;
  end

  assign REQ_READY = !RST && (credits < CW'(FIFO_DEPTH));
  assign accept    = REQ_VALID && REQ_READY;
  assign BRAM_EN   = accept;
  assign BRAM_WE   = accept && REQ_WRITE;
  assign BRAM_ADDR = REQ_ADDR;
  assign BRAM_DI   = REQ_DATA;

  assign push      = rd_pipe[LAT-1];
  assign RSP_VALID = (occ != '0);
  assign pop       = RSP_VALID && RSP_READY;
  assign RSP_DATA  = fifo_mem[head];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pipe <= '0;
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | LAT'(accept && !REQ_WRITE);
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[tail] <= BRAM_DO;
  end

endmodule

// File: tb/tb_bram1_load_client.sv
// Bench for bram1_load_client: both latencies side by side, each with its own behavioural BRAM,
// checked against a request-order queue model with acceptance-time-based response visibility.
module tb_bram1_load_client;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst       [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_write [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_data  [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          bram_en   [2];
  logic          bram_we   [2];
  logic [AW-1:0] bram_addr [2];
  logic [DW-1:0] bram_di   [2];
  logic [DW-1:0] bram_do   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [16];
    logic [DW-1:0] q0;
    logic [DW-1:0] q1;

    bram1_load_client #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .PIPELINED (g),
      .FIFO_DEPTH(DEPTH)
    ) dut (
      .CLK      (clk),
      .RST      (rst[g]),
      .REQ_VALID(req_valid[g]),
      .REQ_READY(req_ready[g]),
      .REQ_WRITE(req_write[g]),
      .REQ_ADDR (req_addr[g]),
      .REQ_DATA (req_data[g]),
      .RSP_VALID(rsp_valid[g]),
      .RSP_READY(rsp_ready[g]),
      .RSP_DATA (rsp_data[g]),
      .BRAM_EN  (bram_en[g]),
      .BRAM_WE  (bram_we[g]),
      .BRAM_ADDR(bram_addr[g]),
      .BRAM_DI  (bram_di[g]),
      .BRAM_DO  (bram_do[g])
    );

    initial for (int i = 0; i < 16; i++) mem[i] <= DW'(i);

    // Write-first single port; the pipelined variant adds an output register.
    always @(posedge clk) begin
      if (bram_en[g]) begin
        if (bram_we[g]) begin
          mem[bram_addr[g]] <= bram_di[g];
          q0 <= bram_di[g];
        end else begin
          q0 <= mem[bram_addr[g]];
        end
      end
      q1 <= q0;
    end

    assign bram_do[g] = (g == 0) ? q0 : q1;
  end

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  typedef struct {
    int            k;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          has_rsp;
    logic [DW-1:0] exp_d;
    int            exp_lat;
  } vec_t;

  exp_t          eq [$];
  logic [DW-1:0] refmem [2][16];
  logic [DW-1:0] got_q [$];
  int            gotc_q [$];
  int            cyc;
  int            last_acc;
  logic          last_fire;
  int            n_tests;
  int            n_fail;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d cyc=%0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // One clock of stimulus on instance k with full model checking.
  task automatic cycle(input int k, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    logic          exp_ready, exp_valid, fire, pop;
    logic [DW-1:0] seen;
    int            lat;
    lat = k + 1;
    @(negedge clk);
    exp_ready = (eq.size() < DEPTH);
    exp_valid = (eq.size() > 0) && (cyc >= eq[0].acc + lat);
    seen      = rsp_data[k];
    chk("req_ready", k, 32'(req_ready[k]), 32'(exp_ready));
    chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(exp_valid));
    if (exp_valid) chk("rsp_data", k, 32'(seen), 32'(eq[0].data));
    req_valid[k] = v;
    req_write[k] = w;
    req_addr[k]  = a;
    req_data[k]  = d;
    rsp_ready[k] = rr;
    #1;
    fire = v && exp_ready;
    pop  = exp_valid && rr;
    chk("bram_en", k, 32'(bram_en[k]), 32'(fire));
    if (fire) begin
      chk("bram_we", k, 32'(bram_we[k]), 32'(w));
      chk("bram_addr", k, 32'(bram_addr[k]), 32'(a));
      if (w) chk("bram_di", k, 32'(bram_di[k]), 32'(d));
    end
    if (pop) begin
      got_q.push_back(seen);
      gotc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    last_fire = fire;
    if (pop) void'(eq.pop_front());
    if (fire && !w) begin
      eq.push_back('{data: refmem[k][a], acc: cyc});
      last_acc = cyc;
    end
    if (fire && w) refmem[k][a] = d;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) cycle(k, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst[k]       = 1'b1;
    req_valid[k] = 1'b1;
    req_write[k] = 1'b0;
    #1;
    chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
    chk("rst_req_ready", k, 32'(req_ready[k]), 32'd0);
    chk("rst_bram_en", k, 32'(bram_en[k]), 32'd0);
    @(posedge clk);
    cyc++;
    eq.delete();
    @(negedge clk);
    rst[k]       = 1'b0;
    req_valid[k] = 1'b0;
    #1;
    chk("rel_req_ready", k, 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    cyc++;
  endtask

  vec_t vecs [8];

  initial begin
    int fires;
    int first_acc;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_data[k]  = '0;
      rsp_ready[k] = 1'b0;
      for (int i = 0; i < 16; i++) refmem[k][i] = DW'(i);
    end

    vecs[0] = '{0, 1'b0, 4'd5,  8'h00, 1'b1, 8'h05, 1};
    vecs[1] = '{1, 1'b0, 4'd5,  8'h00, 1'b1, 8'h05, 2};
    vecs[2] = '{0, 1'b1, 4'd3,  8'hA5, 1'b0, 8'h00, 0};
    vecs[3] = '{1, 1'b1, 4'd3,  8'hC3, 1'b0, 8'h00, 0};
    vecs[4] = '{0, 1'b0, 4'd3,  8'h00, 1'b1, 8'hA5, 1};
    vecs[5] = '{1, 1'b0, 4'd3,  8'h00, 1'b1, 8'hC3, 2};
    vecs[6] = '{0, 1'b0, 4'd4,  8'h00, 1'b1, 8'h04, 1};
    vecs[7] = '{1, 1'b0, 4'd15, 8'h00, 1'b1, 8'h0F, 2};

    // Reset state with a request pending
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", k, 32'(req_ready[k]), 32'd0);
      chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      chk("reset_bram_en", k, 32'(bram_en[k]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      rst[k]       = 1'b0;
    end
    @(posedge clk);

    // Back-to-back reads, pipelined BRAM, no stall
    got_q.delete(); gotc_q.delete();
    fires = 0; first_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1'b1, 1'b0, AW'(i), '0, 1'b1);
      if (last_fire) fires++;
      if (i == 0) first_acc = last_acc;
    end
    idle(1, 4);
    chk("b2b_accepted", 1, 32'(fires), 32'd8);
    chk("b2b_count", 1, 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk("b2b_data", 1, 32'(got_q[i]), 32'(i));
      chk("b2b_time", 1, 32'(gotc_q[i] - first_acc), 32'(2 + i));
    end

    // Table of isolated transactions
    for (int t = 0; t < 8; t++) begin
      got_q.delete(); gotc_q.delete();
      cycle(vecs[t].k, 1'b1, vecs[t].w, vecs[t].a, vecs[t].d, 1'b1);
      idle(vecs[t].k, 4);
      chk("vec_count", vecs[t].k, 32'(got_q.size()), 32'(vecs[t].has_rsp));
      if (vecs[t].has_rsp && got_q.size() > 0) begin
        chk("vec_data", vecs[t].k, 32'(got_q[0]), 32'(vecs[t].exp_d));
        chk("vec_latency", vecs[t].k, 32'(gotc_q[0] - last_acc), 32'(vecs[t].exp_lat));
      end
    end

    // Write then immediate read of same address, then another read
    for (int k = 0; k < 2; k++) begin
      got_q.delete(); gotc_q.delete();
      cycle(k, 1'b1, 1'b1, 4'd3, 8'h5A, 1'b1);
      cycle(k, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
      cycle(k, 1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
      idle(k, 4);
      chk("raw_count", k, 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
        chk("raw_first", k, 32'(got_q[0]), 32'h5A);
        chk("raw_second", k, 32'(got_q[1]), 32'h04);
      end
    end

    // Consumer stalled: exactly DEPTH reads accepted, then drain
    for (int k = 0; k < 2; k++) begin
      got_q.delete(); gotc_q.delete();
      fires = 0;
      for (int i = 0; i < 8; i++) begin
        cycle(k, 1'b1, 1'b0, AW'(8 + i), '0, 1'b0);
        if (last_fire) fires++;
      end
      chk("stall_accepted", k, 32'(fires), 32'(DEPTH));
      #2;
      chk("stall_req_ready", k, 32'(req_ready[k]), 32'd0);
      chk("stall_rsp_valid", k, 32'(rsp_valid[k]), 32'd1);
      chk("stall_head", k, 32'(rsp_data[k]), 32'd8);
      cycle(k, 1'b0, 1'b0, '0, '0, 1'b1);
      #2;
      chk("credit_return", k, 32'(req_ready[k]), 32'd1);
      idle(k, 5);
      chk("drain_count", k, 32'(got_q.size()), 32'(DEPTH));
      for (int i = 0; i < DEPTH && i < got_q.size(); i++)
        chk("drain_data", k, 32'(got_q[i]), 32'(8 + i));
    end

    // Reset with two FIFO entries and two reads in flight
    for (int i = 0; i < 4; i++) cycle(1, 1'b1, 1'b0, AW'(i + 1), '0, 1'b0);
    do_reset(1);
    got_q.delete(); gotc_q.delete();
    idle(1, 6);
    chk("post_reset_rsp", 1, 32'(got_q.size()), 32'd0);
    cycle(1, 1'b1, 1'b0, 4'd3, '0, 1'b1);
    idle(1, 4);
    chk("post_reset_count", 1, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("bram_retained", 1, 32'(got_q[0]), 32'h5A);

    // Random stress against the model, including one mid-stream reset
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3000; i++) begin
        logic rr;
        if (i == 1500) do_reset(k);
        rr = ((i % 200) < 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
        cycle(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              AW'($urandom_range(0, 15)), DW'($urandom), rr);
      end
      idle(k, 12);
      chk("stress_drained", k, 32'(eq.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
